// File: rtl/cache_sched_pkg.sv
// Shared types and helpers for the cache line scheduler and its victim selector.
package cache_sched_pkg;

  localparam int unsigned MAX_LINES = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    ISSUE      = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4,
    SETTLE     = 3'd5
  } sched_state_t;

  // Callers cast the result down to their own line count.
  function automatic logic [MAX_LINES-1:0] onehot(input int idx);
    logic [MAX_LINES-1:0] vec;
    for (int i = 0; i < MAX_LINES; i++) begin
      vec[i] = (i == idx);
    end
    return vec;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Picks the ready line with the smallest TTL; ties resolve to the lowest index.
module cache_victim_select #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TTLBITS   = 8,
  parameter int unsigned IDXBITS   = $clog2(NUM_LINES)
) (
  input  logic [NUM_LINES-1:0]         ready,
  input  logic [NUM_LINES*TTLBITS-1:0] ttl,
  output logic [IDXBITS-1:0]           idx,
  output logic                         found
);

  logic [TTLBITS-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '1;
    for (int i = 0; i < NUM_LINES; i++) begin
      // Strict less-than keeps the earlier (lower) index on equal TTLs.
      if (ready[i] && (!found || (ttl[i*TTLBITS +: TTLBITS] < best))) begin
        found = 1'b1;
        idx   = IDXBITS'(i);
        best  = ttl[i*TTLBITS +: TTLBITS];
      end
    end
  end

endmodule

// File: rtl/cache_line_scheduler.sv
// Refill scheduler for a bank of cache lines sharing one memory port: detects a global
// miss, picks a victim, issues one fill/flush command and pauses the other lines.
module cache_line_scheduler
  import cache_sched_pkg::*;
#(
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned LSBBITS   = 7,
  parameter int unsigned TTLBITS   = 8,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDXBITS   = $clog2(NUM_LINES),
  parameter int unsigned CNTBITS   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  input  logic [ADDRBITS-1:0]          req_addr,
  input  logic [NUM_LINES-1:0]         line_miss,
  input  logic [NUM_LINES-1:0]         line_dirty,
  input  logic [NUM_LINES-1:0]         line_ready,
  input  logic [NUM_LINES*TTLBITS-1:0] line_ttl,
  input  logic                         mem_busy,
  output logic [NUM_LINES-1:0]         line_flush,
  output logic [NUM_LINES-1:0]         line_fill,
  output logic [ADDRBITS-1:0]          new_region,
  output logic [NUM_LINES-1:0]         line_pause,
  output logic                         busy,
  output logic [IDXBITS-1:0]           victim_idx,
  output logic [CNTBITS-1:0]           miss_count
);

  sched_state_t         state_q, state_d;
  logic [ADDRBITS-1:0]  region_q;
  logic [IDXBITS-1:0]   victim_q;
  logic [NUM_LINES-1:0] fill_q, flush_q, pause_q;
  logic                 busy_q;
  logic [CNTBITS-1:0]   count_q;

  logic                 global_miss;
  logic                 sel_found;
  logic [IDXBITS-1:0]   sel_idx;
  logic [NUM_LINES-1:0] sel_oh, victim_oh;
  logic                 waiting;
  logic                 unused_addr;

  assign unused_addr = ^req_addr[LSBBITS-1:0];
  assign global_miss = req_valid & (&line_miss);
  assign sel_oh      = NUM_LINES'(onehot(int'(sel_idx)));
  assign victim_oh   = NUM_LINES'(onehot(int'(victim_q)));
  assign waiting     = (state_q == WAIT_START) || (state_q == WAIT_DONE);

  cache_victim_select #(
    .NUM_LINES (NUM_LINES),
    .TTLBITS   (TTLBITS),
    .IDXBITS   (IDXBITS)
  ) u_victim_select (
    .ready (line_ready),
    .ttl   (line_ttl),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (global_miss)           state_d = SELECT;
      SELECT:     if (sel_found)             state_d = ISSUE;
      ISSUE:                                 state_d = WAIT_START;
      WAIT_START: if (!line_ready[victim_q]) state_d = WAIT_DONE;
      WAIT_DONE:  if (line_ready[victim_q])  state_d = SETTLE;
      SETTLE:                                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      region_q <= '0;
      victim_q <= '0;
      fill_q   <= '0;
      flush_q  <= '0;
      pause_q  <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      fill_q  <= '0;
      flush_q <= '0;
      // Pause reflects this cycle's state, so it trails the condition by one cycle.
      pause_q <= {NUM_LINES{mem_busy}} | (waiting ? ~victim_oh : '0);
      if ((state_q == IDLE) && global_miss) begin
        region_q <= {req_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
      end
      if ((state_q == SELECT) && sel_found) begin
        victim_q <= sel_idx;
        fill_q   <= sel_oh;
        flush_q  <= sel_oh & line_dirty;
      end
      if ((state_q == ISSUE) && (count_q != '1)) begin
        count_q <= count_q + CNTBITS'(1);
      end
    end
  end

  assign line_fill  = fill_q;
  assign line_flush = flush_q;
  assign line_pause = pause_q;
  assign new_region = region_q;
  assign busy       = busy_q;
  assign victim_idx = victim_q;
  assign miss_count = count_q;

endmodule

// File: tb/tb_cache_line_scheduler.sv
// Randomised and directed bench for cache_line_scheduler against a refill-sequence model.
module tb_cache_line_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  line_miss, line_dirty, line_ready;
  logic [31:0] line_ttl;
  logic        mem_busy;

  logic [3:0]  fill_a, flush_a, pause_a;
  logic [31:0] region_a;
  logic        busy_a;
  logic [1:0]  victim_a;
  logic [15:0] count_a;

  logic [3:0]  fill_b, flush_b, pause_b;
  logic [31:0] region_b;
  logic        busy_b;
  logic [1:0]  victim_b;
  logic [1:0]  count_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Model of the refill sequence: 0 idle, 1 select, 2 issue, 3 wait start, 4 wait done, 5 settle.
  int          m_phase;
  int          m_victim;
  int          m_count;
  logic [31:0] m_region;
  logic [3:0]  m_fill, m_flush, m_pause;
  logic        m_busy;

  always #5 clk = ~clk;

  cache_line_scheduler u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .line_miss  (line_miss),
    .line_dirty (line_dirty),
    .line_ready (line_ready),
    .line_ttl   (line_ttl),
    .mem_busy   (mem_busy),
    .line_flush (flush_a),
    .line_fill  (fill_a),
    .new_region (region_a),
    .line_pause (pause_a),
    .busy       (busy_a),
    .victim_idx (victim_a),
    .miss_count (count_a)
  );

  cache_line_scheduler #(.CNTBITS(2)) u_dut_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .line_miss  (line_miss),
    .line_dirty (line_dirty),
    .line_ready (line_ready),
    .line_ttl   (line_ttl),
    .mem_busy   (mem_busy),
    .line_flush (flush_b),
    .line_fill  (fill_b),
    .new_region (region_b),
    .line_pause (pause_b),
    .busy       (busy_b),
    .victim_idx (victim_b),
    .miss_count (count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int best;
    int bi;
    logic [3:0] nxt_pause;
    if (!reset_n) begin
      m_phase = 0; m_victim = 0; m_count = 0; m_region = '0;
      m_fill = '0; m_flush = '0; m_pause = '0; m_busy = 1'b0;
      return;
    end
    nxt_pause = mem_busy ? 4'hF : 4'h0;
    if (m_phase == 3 || m_phase == 4) nxt_pause = nxt_pause | ~(4'b0001 << m_victim);
    m_pause = nxt_pause;
    m_fill  = '0;
    m_flush = '0;
    case (m_phase)
      0: if (req_valid && line_miss == 4'hF) begin
        m_region = req_addr & 32'hFFFF_FF80;
        m_phase  = 1;
      end
      1: begin
        bi   = -1;
        best = 256;
        for (int i = 0; i < 4; i++) begin
          if (line_ready[i] && int'(line_ttl[i*8 +: 8]) < best) begin
            best = int'(line_ttl[i*8 +: 8]);
            bi   = i;
          end
        end
        if (bi >= 0) begin
          m_victim = bi;
          m_fill   = 4'b0001 << bi;
          m_flush  = m_fill & line_dirty;
          m_phase  = 2;
        end
      end
      2: begin
        m_count++;
        m_phase = 3;
      end
      3: if (!line_ready[m_victim]) m_phase = 4;
      4: if (line_ready[m_victim]) m_phase = 5;
      default: m_phase = 0;
    endcase
    m_busy = (m_phase != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("fill",       32'(fill_a),   32'(m_fill));
      check("flush",      32'(flush_a),  32'(m_flush));
      check("pause",      32'(pause_a),  32'(m_pause));
      check("region",     region_a,      m_region);
      check("busy",       32'(busy_a),   32'(m_busy));
      check("victim",     32'(victim_a), 32'(m_victim));
      check("count",      32'(count_a),  32'((m_count > 65535) ? 65535 : m_count));
      check("fill_s",     32'(fill_b),   32'(m_fill));
      check("busy_s",     32'(busy_b),   32'(m_busy));
      check("count_s",    32'(count_b),  32'((m_count > 3) ? 3 : m_count));
    end
  end

  task automatic do_refill();
    req_valid = 1'b1; line_miss = 4'hF; line_ready = 4'hF;
    cycle();
    req_valid = 1'b0;
    cycle();
    line_ready = 4'b1101;
    cycle();
    cycle();
    line_ready = 4'hF;
    cycle();
    cycle();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0000_1234;
    line_miss = '0; line_dirty = '0; line_ready = 4'hF; mem_busy = 1'b0;
    line_ttl = {8'd40, 8'd10, 8'd10, 8'd90};
    cycle();
    check_en = 1'b1;
    cycle();
    reset_n = 1'b1;
    cycle();

    // Clean refill with a TTL tie between lines 1 and 2.
    req_valid = 1'b1; line_miss = 4'hF;
    cycle();
    req_valid = 1'b0;
    check("t1_busy", 32'(busy_a), 32'd1);
    check("t1_nofill", 32'(fill_a), 32'd0);
    cycle();
    check("t1_fill", 32'(fill_a), 32'h2);
    check("t1_flush", 32'(flush_a), 32'h0);
    check("t1_victim", 32'(victim_a), 32'd1);
    check("t1_region", region_a, 32'h0000_1200);
    line_ready = 4'b1101;
    cycle();
    check("t1_count", 32'(count_a), 32'd1);
    check("t1_fill_once", 32'(fill_a), 32'h0);
    cycle();
    line_ready = 4'hF;
    cycle();
    cycle();
    check("t1_idle", 32'(busy_a), 32'd0);

    // Dirty victim: flush and fill together for one cycle.
    line_dirty = 4'b0010; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    check("t2_flush", 32'(flush_a), 32'h2);
    check("t2_fill", 32'(fill_a), 32'h2);
    line_ready = 4'b1101;
    cycle();
    check("t2_flush_once", 32'(flush_a), 32'h0);
    cycle();
    line_ready = 4'hF; line_dirty = '0;
    cycle();
    cycle();

    // No candidates during select, then only line 2 becomes ready.
    line_ready = 4'h0; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_hold_busy", 32'(busy_a), 32'd1);
      check("t3_hold_fill", 32'(fill_a), 32'd0);
    end
    line_ready = 4'b0100; line_ttl = {8'd40, 8'd200, 8'd10, 8'd90};
    cycle();
    check("t3_victim", 32'(victim_a), 32'd2);
    check("t3_fill", 32'(fill_a), 32'h4);

    // Pause behaviour around victim 2.
    line_ready = 4'h0;
    cycle();
    cycle();
    check("t4_pause", 32'(pause_a), 32'hB);
    mem_busy = 1'b1;
    cycle();
    check("t4_pause_mem", 32'(pause_a), 32'hF);
    line_ready = 4'b0100; mem_busy = 1'b0;
    cycle();
    check("t4_settle_busy", 32'(busy_a), 32'd1);
    cycle();
    check("t4_busy_low", 32'(busy_a), 32'd0);
    check("t4_pause_low", 32'(pause_a), 32'h0);
    line_ready = 4'hF; line_ttl = {8'd40, 8'd10, 8'd10, 8'd90};

    // Reset while waiting for the victim, with the miss held.
    req_valid = 1'b1;
    cycle();
    cycle();
    line_ready = 4'b1101;
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_count", 32'(count_a), 32'd0);
    check("t5_region", region_a, 32'd0);
    reset_n = 1'b1;
    cycle();
    check("t5_restart", 32'(busy_a), 32'd1);
    cycle();
    check("t5_fill", 32'(fill_a), 32'h4);
    req_valid = 1'b0; line_ready = 4'b1011;
    cycle();
    cycle();
    line_ready = 4'hF;
    cycle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      reset_n    = ($urandom_range(0, 499) != 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_addr   = $urandom;
      line_miss  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      line_dirty = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        line_ready[i] = ($urandom_range(0, 3) != 0);
        line_ttl[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3))
                                                         : 8'($urandom);
      end
      mem_busy = ($urandom_range(0, 4) == 0);
      cycle();
    end

    // Saturation: the 2-bit counter sticks at 3 while the wide one keeps counting.
    reset_n = 1'b0; req_valid = 1'b0; line_dirty = '0; mem_busy = 1'b0; line_ready = 4'hF;
    line_ttl = {8'd40, 8'd10, 8'd10, 8'd90};
    cycle();
    reset_n = 1'b1;
    cycle();
    for (int r = 0; r < 4; r++) do_refill();
    check("sat_small", 32'(count_b), 32'd3);
    check("sat_wide", 32'(count_a), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_scheduler.md
Name: cache_line_scheduler

Overview:
- Controls a bank of NUM_LINES cache_line instances that share one memory port.
- Detects a global miss (every line misses a pending request) and picks a victim line: lowest TTL among ready lines.
- Commands the victim to fill, or to flush then fill when dirty. Pauses the other lines while the refill owns the memory port.
- Keeps a saturating miss counter for performance monitoring.

Parameters:
- ADDRBITS, 32, address width.
- LSBBITS, 7, byte-offset bits inside one line; region = addr[ADDRBITS-1:LSBBITS].
- TTLBITS, 8, width of each line's TTL.
- NUM_LINES, 4, number of managed lines (2..16).
- IDXBITS, $clog2(NUM_LINES), victim index width.
- CNTBITS, 16, miss counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  a dcache/icache request is pending this cycle.
- req_addr  in  ADDRBITS  address of the pending request.
- line_miss  in  NUM_LINES  per-line miss flag.
- line_dirty  in  NUM_LINES  per-line dirty flag.
- line_ready  in  NUM_LINES  per-line ready flag (1 = caching, idle).
- line_ttl  in  NUM_LINES*TTLBITS  packed TTLs; line i occupies [i*TTLBITS +: TTLBITS].
- mem_busy  in  1  memory controller overloaded.
- line_flush  out  NUM_LINES  one-hot flush command.
- line_fill  out  NUM_LINES  one-hot fill command.
- new_region  out  ADDRBITS  region to load; low LSBBITS bits always 0.
- line_pause  out  NUM_LINES  per-line pause.
- busy  out  1  refill sequence in progress.
- victim_idx  out  IDXBITS  index of the current/last victim.
- miss_count  out  CNTBITS  number of refills started, saturating.

Behaviour:
- Reset: synchronous, taken on the clk edge while reset_n=0. Overrides any state, including mid-refill. All outputs go to 0; FSM goes to IDLE.
- global_miss = req_valid & (&line_miss).
- States:
  - IDLE: on global_miss, latch region = {req_addr[ADDRBITS-1:LSBBITS], LSBBITS'b0}; go to SELECT.
  - SELECT:
    - Candidates are lines with line_ready=1.
    - Victim = candidate with the smallest TTL (unsigned compare); ties go to the lowest index.
    - Register victim_idx; go to ISSUE.
    - If there are no candidates, stay in SELECT.
  - ISSUE: for exactly one cycle, drive line_fill[v]=1, and line_flush[v]=line_dirty[v]. new_region holds the latched value. Increment miss_count unless it is already all-ones. Go to WAIT_START.
  - WAIT_START: when line_ready[v]=0 (line accepted), go to WAIT_DONE. Commands are never re-issued.
  - WAIT_DONE: when line_ready[v]=1, go to SETTLE.
  - SETTLE: one cycle so line_miss reflects the new region; go to IDLE. global_miss is not evaluated in this cycle.
- Command latency: global_miss in cycle N gives line_fill in cycle N+2 (registered outputs).
- busy = 1 in SELECT through SETTLE.
- line_pause[i] = mem_busy | (busy & (i != victim_idx) & state in {WAIT_START, WAIT_DONE}). Registered: visible one cycle after the condition.
- new_region holds its value until the next latch; it is 0 after reset.
- If req_valid drops after IDLE, the sequence still completes (acts as a prefetch).
- If any line hits while busy, nothing changes; the scheduler never aborts.
- If a second global_miss arrives while busy, it is ignored. It is re-evaluated in IDLE after SETTLE.
- line_flush and line_fill are never asserted for more than one line, or for more than one cycle per sequence.

Decomposition:
- Package cache_sched_pkg:
  - FSM state localparams: IDLE, SELECT, ISSUE, WAIT_START, WAIT_DONE, SETTLE (3-bit).
  - Function onehot(idx) returning NUM_LINES bits.
- Sub-module cache_victim_select: combinational min-TTL reduction over ready lines with lowest-index tie-break. Outputs victim index and a found flag.

Test Plan (NUM_LINES=4, TTLBITS=8):
- Clean refill. Stimulus: all lines miss and ready, ttl={40,10,10,90} (lines 3..0), dirty=0000, req_addr=0x0000_1234. Response: victim_idx=1 (tie broken to lowest index); line_fill=0010 for one cycle, 2 cycles after the miss; line_flush=0000; new_region=0x0000_1200; miss_count=1.
- Dirty victim. Same stimulus with line_dirty=0010. Response: line_flush=0010 and line_fill=0010 in the same single cycle.
- Not-ready lines. Stimulus: line_ready=0000 during SELECT for 5 cycles, then line 2 ready (ttl=200). Response: stays in SELECT, no commands; then victim_idx=2, line_fill=0100.
- Pause. Stimulus: mem_busy=0 during WAIT_DONE with victim=2. Response: line_pause=1011. Then mem_busy=1. Response: line_pause=1111. After line_ready[2] rises: busy falls 2 cycles later, and line_pause=0000 once mem_busy=0.
- Reset mid-operation. Stimulus: reset_n=0 for one edge during WAIT_DONE. Response: all outputs 0, state IDLE; a held global_miss restarts the sequence afterwards.
- Saturation. Stimulus: preload to 16'hFFFE, run 3 refills. Response: miss_count=16'hFFFF, no wrap.
